// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide datapath.
// Holds the datapath width, the 2-bit mul/div op codes and the mul/div FSM encoding.
// Small helpers decode the op code into its divide / signed attributes.
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ITER  = 2'd2,
    ST_FIX   = 2'd3
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
// Purely combinational, zero latency.
// No flow control; output follows the inputs.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// Fixed latency: start accepted at edge n commits HI/LO (and pulses done) at edge n+34.
// start is only accepted while idle; requests and MTHI/MTLO while busy are dropped.
module mult_div_unit #(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t          state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  // x_r shifts: multiplier (right) for multiply, dividend (left) for divide.
  // y_r is fixed: multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  // Multiply: running product. Divide: {partial remainder, quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               res_sign;
  logic               dvd_sign;

  logic               is_div;
  logic               is_signed;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   div_rem_next;

  assign is_div    = op_is_div(op_r);
  assign is_signed = op_is_signed(op_r);
  assign b_zero    = (b_r == '0);

  // Operand magnitudes; unsigned ops pass straight through.
  twos_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg  (is_signed & a_r[WIDTH-1]),
    .din  (a_r),
    .dout (mag_a)
  );

  twos_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg  (is_signed & b_r[WIDTH-1]),
    .din  (b_r),
    .dout (mag_b)
  );

  // Result fix-ups: full product, quotient (result sign), remainder (dividend sign).
  twos_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .neg  (res_sign),
    .din  (acc),
    .dout (prod_fix)
  );

  twos_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .neg  (res_sign),
    .din  (acc[WIDTH-1:0]),
    .dout (quo_fix)
  );

  twos_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .neg  (dvd_sign),
    .din  (acc[2*WIDTH-1:WIDTH]),
    .dout (rem_fix)
  );

  // One step of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (x_r[0] ? y_r : '0)};
    div_shift    = {acc[2*WIDTH-1:WIDTH], x_r[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, y_r});
    // The remainder stays below the divisor, so the low WIDTH bits suffice.
    div_sub      = div_shift[WIDTH-1:0] - y_r;
    div_rem_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
  end

  // Operand capture, setup and per-cycle iteration of the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= OP_MULT;
      a_r      <= '0;
      b_r      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_sign <= 1'b0;
      dvd_sign <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
          end
        end
        ST_SETUP: begin
          acc      <= '0;
          cnt      <= '0;
          res_sign <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          dvd_sign <= is_signed & a_r[WIDTH-1];
          if (is_div) begin
            x_r <= mag_a;
            y_r <= mag_b;
          end else begin
            x_r <= mag_b;
            y_r <= mag_a;
          end
        end
        ST_ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc <= {div_rem_next, acc[WIDTH-2:0], div_ge};
            x_r <= x_r << 1;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            x_r <= x_r >> 1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control FSM with registered busy/done/div_by_zero and the HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          // MTHI/MTLO land even if start is accepted on the same edge.
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            state <= ST_SETUP;
            busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          state <= ST_ITER;
        end
        ST_ITER: begin
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div) begin
            if (b_zero) begin
              hi          <= a_r;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
// Drives on negedges and samples on negedges, away from the active edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Reference: MIPS semantics computed with 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    rz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'd0: {rh, rl} = sx * sy;
      2'd1: {rh, rl} = ux * uy;
      default: begin
        if (y == 32'd0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
          rz = 1'b1;
        end else if (o == 2'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          rl = sq[31:0];
          rh = sr[31:0];
        end else begin
          uq = ux / uy;
          ur = ux % uy;
          rl = uq[31:0];
          rh = ur[31:0];
        end
      end
    endcase
  endfunction

  // One operation: checks acceptance, HI/LO hold mid-op, latency and results.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string nm, input bit b2b, input int poke_k, input bit wr_with_start);
    logic [31:0] eh, el;
    logic ez, dz, bz;
    int lat;
    model(o, x, y, eh, el, ez);
    dz = 1'b0;
    bz = 1'b1;
    if (!b2b) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL %s idle_done: got %b want 0", nm, done);
      end
    end
    start = 1'b1; op = o; a = x; b = y;
    if (wr_with_start) begin
      wr_hi = 1'b1;
      wr_data = 32'hA5A5_0F0F;
    end
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s accept_busy: got %b want 1", nm, busy);
    end
    if (wr_with_start) begin
      checks++;
      if (hi !== 32'hA5A5_0F0F) begin
        failures++;
        $display("FAIL %s mthi_with_start: hi got %h want a5a50f0f", nm, hi);
      end
      exp_hi = 32'hA5A5_0F0F;
    end
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      if (k == poke_k) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = $urandom;
      end
      if (k == 20) begin
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
          failures++;
          $display("FAIL %s hold: hi/lo got %h/%h want %h/%h", nm, hi, lo, exp_hi, exp_lo);
        end
      end
      if (done === 1'b1) begin
        lat = k;
        dz = div_by_zero;
        bz = busy;
      end
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    checks++;
    if (lat != 34) begin
      failures++;
      $display("FAIL %s latency: got %0d want 34", nm, lat);
    end
    checks++;
    if (hi !== eh) begin
      failures++;
      $display("FAIL %s hi: got %h want %h", nm, hi, eh);
    end
    checks++;
    if (lo !== el) begin
      failures++;
      $display("FAIL %s lo: got %h want %h", nm, lo, el);
    end
    checks++;
    if (dz !== ez) begin
      failures++;
      $display("FAIL %s div_by_zero: got %b want %b", nm, dz, ez);
    end
    checks++;
    if (bz !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b want 0", nm, bz);
    end
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy/done/dbz %b%b%b hi %h lo %h want 000 0 0",
               busy, done, div_by_zero, hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  to [8];
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    to = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
    ta = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
           32'd100, 32'd5, 32'h8000_0000, 32'hDEAD_BEEF};
    tb = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd2,
           32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 8; i++) do_op(to[i], ta[i], tb[i], $sformatf("directed%0d", i), 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 1000)) - 32'd500;
      do_op(o, x, y, $sformatf("random%0d", i), 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_busy_ignore();
    do_op(2'd0, 32'h0001_2345, 32'hFFFF_0007, "busy_ignore_mul", 1'b0, 10, 1'b0);
    do_op(2'd2, 32'h7654_3210, 32'h0000_0123, "busy_ignore_div", 1'b0, 10, 1'b0);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    wr_lo = 1'b0;
    checks++;
    if (lo !== 32'h0000_1234 || hi !== exp_hi) begin
      failures++;
      $display("FAIL mtlo: hi/lo got %h/%h want %h/00001234", hi, lo, exp_hi);
    end
    exp_lo = 32'h0000_1234;
    wr_hi = 1'b1; wr_data = 32'hCAFE_0001;
    @(negedge clk);
    wr_hi = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_0001 || lo !== exp_lo) begin
      failures++;
      $display("FAIL mthi: hi/lo got %h/%h want cafe0001/%h", hi, lo, exp_lo);
    end
    exp_hi = 32'hCAFE_0001;
    do_op(2'd1, 32'd3, 32'd5, "mthi_with_start", 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_inflight: busy got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy %b done %b hi %h lo %h want 0 0 0 0", busy, done, hi, lo);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d pulses want 0", seen);
    end
    exp_hi = '0;
    exp_lo = '0;
    do_op(2'd3, 32'd1000, 32'd33, "after_reset", 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op(2'd0, 32'hFFFF_FF00, 32'h0000_0100, "b2b_first", 1'b0, 0, 1'b0);
    do_op(2'd2, 32'hFFFF_FF9C, 32'd9, "b2b_second", 1'b1, 0, 1'b0);
    do_op(2'd1, 32'h0F0F_0F0F, 32'h1000_0001, "b2b_third", 1'b1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
